// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy, half-level and programmable threshold
// flags, a fill count, sticky overflow/underflow errors and an optional
// first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  half_full,
    output logic                  half_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_HALF  = PW'(DEPTH / 2);
    localparam logic [ADDR_WIDTH:0] C_ONE   = PW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Occupancy is the modular pointer difference; the wrap bit makes the
    // full and empty cases distinguishable.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];
    assign w_full    = (w_count == C_DEPTH);
    assign w_empty   = (w_count == '0);

    // Acceptance looks only at the flags as they stand at the edge, so a
    // read never frees room for a same-cycle write and vice versa. Reset
    // blocks both so nothing lands in memory during the reset cycle.
    assign w_wr_accept = wr_en && !w_full  && !rst;
    assign w_rd_accept = rd_en && !w_empty && !rst;

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign half_full    = (w_count >= C_HALF);
    assign half_empty   = (w_count <  C_HALF);
    assign almost_full  = (w_count >= af_thresh);
    assign almost_empty = (w_count <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Write and read pointers advance on accepted transfers and wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    // Sticky error flags; a new error event in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; an empty FIFO presents zero.
            assign data_out = w_empty ? '0 : r_mem[w_rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            // Registered read port: loads the head word on each accepted read
            // and holds it until the next one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_accept) begin
                    r_data_out <= r_mem[w_rd_addr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

endmodule
